// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding tracker between decode and ID/EX: a shift register of
// in-flight destination registers drives the decode stall and per-port forwarding selects.
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int NRD      = 2,
    parameter int AW       = 5,
    parameter int ALU_RDY  = 0,
    parameter int LOAD_RDY = 1,
    parameter int SW       = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NRD*AW-1:0] src_reg,
    input  logic [NRD-1:0]    src_vld,
    input  logic              iss_vld,
    input  logic [AW-1:0]     iss_rd,
    input  logic              iss_we,
    input  logic              iss_load,
    input  logic              frz,
    input  logic              kill,
    output logic              stall,
    output logic [NRD*SW-1:0] fwd_sel,
    output logic              busy,
    output logic [SW-1:0]     inflight
);

    logic [NSTAGE-1:0] vld_q, vld_d;
    logic [NSTAGE-1:0] load_q, load_d;
    logic [AW-1:0]     rd_q [NSTAGE];
    logic [AW-1:0]     rd_d [NSTAGE];
    logic [SW-1:0]     inflight_q, inflight_d;
    logic [NRD-1:0]    port_stall;
    logic              accept;

    function automatic logic entry_ready(input int k, input logic is_load);
        return is_load ? (k >= LOAD_RDY) : (k >= ALU_RDY);
    endfunction

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        fwd_sel    = '0;
        port_stall = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (src_vld[p] && (src_reg[p*AW +: AW] != '0) && vld_q[k] &&
                    (rd_q[k] == src_reg[p*AW +: AW])) begin
                    if (entry_ready(k, load_q[k])) begin
                        fwd_sel[p*SW +: SW] = SW'(k + 1);
                        port_stall[p]       = 1'b0;
                    end else begin
                        fwd_sel[p*SW +: SW] = '0;
                        port_stall[p]       = 1'b1;
                    end
                end
            end
        end
    end

    assign stall    = |port_stall;
    assign busy     = |vld_q;
    assign inflight = inflight_q;
    assign accept   = iss_vld && !stall && iss_we && (iss_rd != '0);

    always_comb begin
        vld_d      = vld_q;
        load_d     = load_q;
        rd_d       = rd_q;
        inflight_d = inflight_q;
        if (kill) begin
            vld_d      = '0;
            inflight_d = '0;
        end else if (!frz) begin
            for (int k = 1; k < NSTAGE; k++) begin
                vld_d[k]  = vld_q[k-1];
                load_d[k] = load_q[k-1];
                rd_d[k]   = rd_q[k-1];
            end
            vld_d[0]   = accept;
            load_d[0]  = accept && iss_load;
            rd_d[0]    = accept ? iss_rd : '0;
            inflight_d = '0;
            for (int k = 0; k < NSTAGE; k++) begin
                if (vld_d[k]) inflight_d = inflight_d + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q      <= '0;
            load_q     <= '0;
            inflight_q <= '0;
            for (int k = 0; k < NSTAGE; k++) rd_q[k] <= '0;
        end else begin
            vld_q      <= vld_d;
            load_q     <= load_d;
            inflight_q <= inflight_d;
            for (int k = 0; k < NSTAGE; k++) rd_q[k] <= rd_d[k];
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed stimulus queues expected outputs,
// a monitor pops and compares them against a default and a deep/wide instance.
module tb_hazard_scoreboard;

    typedef struct {
        string       name;
        int          inst;
        logic        stall;
        logic [15:0] fwd;
        logic        busy;
        logic [7:0]  infl;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic chk_tog = 1'b0;
    logic clk = 1'b0;

    always #5 clk = ~clk;

    // default instance
    logic       resetn0, iss_vld0, iss_we0, iss_load0, frz0, kill0;
    logic [9:0] src_reg0;
    logic [1:0] src_vld0;
    logic [4:0] iss_rd0;
    logic       stall0, busy0;
    logic [3:0] fwd0;
    logic [1:0] infl0;

    // NSTAGE=5, NRD=3, LOAD_RDY=2 instance
    logic        resetn1, iss_vld1, iss_we1, iss_load1, frz1, kill1;
    logic [14:0] src_reg1;
    logic [2:0]  src_vld1;
    logic [4:0]  iss_rd1;
    logic        stall1, busy1;
    logic [8:0]  fwd1;
    logic [2:0]  infl1;

    hazard_scoreboard u0 (
        .clk(clk), .resetn(resetn0), .src_reg(src_reg0), .src_vld(src_vld0),
        .iss_vld(iss_vld0), .iss_rd(iss_rd0), .iss_we(iss_we0), .iss_load(iss_load0),
        .frz(frz0), .kill(kill0), .stall(stall0), .fwd_sel(fwd0), .busy(busy0),
        .inflight(infl0)
    );

    hazard_scoreboard #(.NSTAGE(5), .NRD(3), .LOAD_RDY(2)) u1 (
        .clk(clk), .resetn(resetn1), .src_reg(src_reg1), .src_vld(src_vld1),
        .iss_vld(iss_vld1), .iss_rd(iss_rd1), .iss_we(iss_we1), .iss_load(iss_load1),
        .frz(frz1), .kill(kill1), .stall(stall1), .fwd_sel(fwd1), .busy(busy1),
        .inflight(infl1)
    );

    task automatic expect_out(input string n, input int inst, input logic s,
                              input logic [15:0] f, input logic b, input logic [7:0] i);
        exp_t e;
        e.name = n; e.inst = inst; e.stall = s; e.fwd = f; e.busy = b; e.infl = i;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        iss_vld0 = 1'b0; iss_rd0 = 5'd0; iss_we0 = 1'b0; iss_load0 = 1'b0;
        src_reg0 = '0; src_vld0 = '0; frz0 = 1'b0; kill0 = 1'b0;
    endtask

    task automatic idle1();
        iss_vld1 = 1'b0; iss_rd1 = 5'd0; iss_we1 = 1'b0; iss_load1 = 1'b0;
        src_reg1 = '0; src_vld1 = '0; frz1 = 1'b0; kill1 = 1'b0;
    endtask

    task automatic issue0(input logic [4:0] rd, input logic ld);
        iss_vld0 = 1'b1; iss_rd0 = rd; iss_we0 = 1'b1; iss_load0 = ld;
    endtask

    task automatic issue1(input logic [4:0] rd, input logic ld);
        iss_vld1 = 1'b1; iss_rd1 = rd; iss_we1 = 1'b1; iss_load1 = ld;
    endtask

    task automatic read0(input int p, input logic [4:0] r);
        src_reg0[p*5 +: 5] = r;
        src_vld0[p]        = 1'b1;
    endtask

    task automatic read1(input int p, input logic [4:0] r);
        src_reg1[p*5 +: 5] = r;
        src_vld1[p]        = 1'b1;
    endtask

    // Monitor: compares on every falling edge, or on demand between edges.
    initial begin
        exp_t        e;
        logic        a_s, a_b;
        logic [15:0] a_f;
        logic [7:0]  a_i;
        forever begin
            @(negedge clk or chk_tog);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.inst == 0) begin
                    a_s = stall0; a_b = busy0; a_f = {12'd0, fwd0}; a_i = {6'd0, infl0};
                end else begin
                    a_s = stall1; a_b = busy1; a_f = {7'd0, fwd1}; a_i = {5'd0, infl1};
                end
                n_chk++;
                if (a_s === e.stall && a_b === e.busy && a_f === e.fwd && a_i === e.infl)
                    n_pass++;
                else
                    $display("FAIL %s: got stall=%0b busy=%0b fwd_sel=%0h inflight=%0d, required stall=%0b busy=%0b fwd_sel=%0h inflight=%0d",
                             e.name, a_s, a_b, a_f, a_i, e.stall, e.busy, e.fwd, e.infl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        idle0(); idle1();
        resetn0 = 1'b0; resetn1 = 1'b0;
        #1;
        expect_out("reset0", 0, 1'b0, 16'h0, 1'b0, 8'd0);
        expect_out("reset1", 1, 1'b0, 16'h0, 1'b0, 8'd0);
        step(); step();
        resetn0 = 1'b1; resetn1 = 1'b1;
        step();

        // ALU back-to-back
        idle0(); issue0(5'd5, 1'b0); expect_out("alu_issue", 0, 1'b0, 16'h0, 1'b0, 8'd0); step();
        idle0(); read0(0, 5'd5); expect_out("alu_e0", 0, 1'b0, 16'h1, 1'b1, 8'd1); step();
        idle0(); read0(0, 5'd5); expect_out("alu_e1", 0, 1'b0, 16'h2, 1'b1, 8'd1); step();
        idle0(); read0(0, 5'd5); expect_out("alu_e2", 0, 1'b0, 16'h3, 1'b1, 8'd1); step();
        idle0(); read0(0, 5'd5); expect_out("alu_retired", 0, 1'b0, 16'h0, 1'b0, 8'd0); step();

        // Load-use
        idle0(); issue0(5'd8, 1'b1); expect_out("ld_issue", 0, 1'b0, 16'h0, 1'b0, 8'd0); step();
        idle0(); issue0(5'd10, 1'b0); read0(1, 5'd8);
        expect_out("ld_use_stall", 0, 1'b1, 16'h0, 1'b1, 8'd1); step();
        idle0(); issue0(5'd10, 1'b0); read0(1, 5'd8);
        expect_out("ld_use_fwd", 0, 1'b0, 16'h8, 1'b1, 8'd1); step();
        idle0(); expect_out("ld_inflight2", 0, 1'b0, 16'h0, 1'b1, 8'd2); step();
        idle0(); read0(1, 5'd10); expect_out("dep_e1", 0, 1'b0, 16'h8, 1'b1, 8'd1); step();
        idle0(); read0(0, 5'd10); expect_out("dep_e2", 0, 1'b0, 16'h3, 1'b1, 8'd1); step();
        idle0(); expect_out("ld_drained", 0, 1'b0, 16'h0, 1'b0, 8'd0); step();

        // Youngest match wins, no fall-through past a not-ready load
        idle0(); issue0(5'd3, 1'b0); step();
        idle0(); expect_out("yg_age", 0, 1'b0, 16'h0, 1'b1, 8'd1); step();
        idle0(); issue0(5'd3, 1'b1); step();
        idle0(); read0(0, 5'd3); expect_out("yg_stall", 0, 1'b1, 16'h0, 1'b1, 8'd2); step();
        idle0(); read0(0, 5'd3); expect_out("yg_fwd_load", 0, 1'b0, 16'h2, 1'b1, 8'd1); step();
        idle0(); step();
        idle0(); expect_out("yg_drained", 0, 1'b0, 16'h0, 1'b0, 8'd0); step();

        // Register zero and non-writing issues are bubbles
        idle0(); iss_vld0 = 1'b1; iss_we0 = 1'b1; iss_rd0 = 5'd0; step();
        idle0(); read0(0, 5'd0); expect_out("r0_read", 0, 1'b0, 16'h0, 1'b0, 8'd0); step();
        idle0(); iss_vld0 = 1'b1; iss_we0 = 1'b0; iss_rd0 = 5'd7; step();
        idle0(); read0(1, 5'd7); expect_out("no_we_read", 0, 1'b0, 16'h0, 1'b0, 8'd0); step();

        // Freeze then kill under freeze
        idle0(); issue0(5'd4, 1'b0); step();
        idle0(); issue0(5'd6, 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            idle0(); frz0 = 1'b1; read0(0, 5'd4); read0(1, 5'd6);
            expect_out("frz_hold", 0, 1'b0, 16'h6, 1'b1, 8'd2); step();
        end
        idle0(); frz0 = 1'b1; kill0 = 1'b1; read0(0, 5'd4); read0(1, 5'd6);
        expect_out("frz_kill_pre", 0, 1'b0, 16'h6, 1'b1, 8'd2); step();
        idle0(); read0(0, 5'd4); read0(1, 5'd6);
        expect_out("kill_clear", 0, 1'b0, 16'h0, 1'b0, 8'd0); step();

        // Kill during a load-use stall
        idle0(); issue0(5'd12, 1'b1); step();
        idle0(); read0(0, 5'd12); kill0 = 1'b1;
        expect_out("kill_stall_pre", 0, 1'b1, 16'h0, 1'b1, 8'd1); step();
        idle0(); read0(0, 5'd12); expect_out("kill_stall_drop", 0, 1'b0, 16'h0, 1'b0, 8'd0); step();

        // Wider/deeper instance: two-cycle load-use, then async reset mid-stall
        idle1(); issue1(5'd9, 1'b1); expect_out("sw_issue", 1, 1'b0, 16'h0, 1'b0, 8'd0); step();
        idle1(); issue1(5'd11, 1'b0); read1(2, 5'd9);
        expect_out("sw_stall_a", 1, 1'b1, 16'h0, 1'b1, 8'd1); step();
        idle1(); issue1(5'd11, 1'b0); read1(2, 5'd9);
        expect_out("sw_stall_b", 1, 1'b1, 16'h0, 1'b1, 8'd1); step();
        idle1(); read1(2, 5'd9); expect_out("sw_fwd", 1, 1'b0, 16'h0C0, 1'b1, 8'd1); step();
        idle1(); issue1(5'd9, 1'b1); expect_out("sw_reissue", 1, 1'b0, 16'h0, 1'b1, 8'd1); step();
        idle1(); read1(2, 5'd9); expect_out("sw_young_stall", 1, 1'b1, 16'h0, 1'b1, 8'd2);
        @(negedge clk);
        #1;
        frz1 = 1'b1; resetn1 = 1'b0;
        #1;
        expect_out("sw_async_reset", 1, 1'b0, 16'h0, 1'b0, 8'd0);
        chk_tog = ~chk_tog;
        step();
        idle1(); step();
        resetn1 = 1'b1; step();
        idle1(); expect_out("sw_post_reset", 1, 1'b0, 16'h0, 1'b0, 8'd0); step();

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding tracker for the in-order MIPS pipeline, sitting between decode and the ID/EX register. It records the destination register of every instruction past decode in a shift register of configurable depth, then generates the decode stall and per-read-port forwarding selects. It replaces hand-written per-stage hazard compares with one block that scales in:

- pipeline depth,
- read-port count,
- load-use latency.

It also supports a global freeze (multi-cycle execute stall) and a kill (pipeline flush).

## Interface
Parameters:
- NSTAGE, 3, tracked post-decode stages; entry 0 = EX, 1 = MEM, 2 = WB.
- NRD, 2, decode read ports (rs, rt, ...).
- AW, 5, register-number width.
- ALU_RDY, 0, first entry index at which a non-load result is forwardable.
- LOAD_RDY, 1, first entry index at which load data is forwardable.
- SW, $clog2(NSTAGE+1), forwarding-select width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- src_reg  in  NRD*AW  decode source register numbers, port p at [p*AW +: AW].
- src_vld  in  NRD  per-port "source is read" flag.
- iss_vld  in  1  decode holds a valid instruction to issue this cycle.
- iss_rd  in  AW  issuing instruction's destination register.
- iss_we  in  1  issuing instruction writes the register file.
- iss_load  in  1  issuing instruction is a load.
- frz  in  1  execute multi-cycle stall; freezes all tracking.
- kill  in  1  flush; invalidates all tracked entries.
- stall  out  1  decode must hold (combinational).
- fwd_sel  out  NRD*SW  per-port source select: 0 = register file, k+1 = entry k.
- busy  out  1  any entry valid (combinational).
- inflight  out  SW  registered count of valid entries.

## Operation
- Each entry k holds {vld, rd, load}.
- Entry k is ready when vld && (load ? k>=LOAD_RDY : k>=ALU_RDY).
- A port p match at entry k requires all of:
  - src_vld[p],
  - src_reg[p] != 0,
  - entry k vld,
  - entry k rd == src_reg[p].
- Youngest match wins: the lowest k overrides older entries.
- fwd_sel[p]:
  - k+1 for the youngest match, if that entry is ready;
  - 0 if there is no match;
  - 0 if the youngest match is not ready. A not-ready entry never falls through to an older match.
- stall = OR over ports of "youngest match not ready". It is independent of frz; the consumer ORs the two.
- Register 0 is never tracked: an issue with iss_rd==0 or !iss_we enters as a bubble (vld=0).
- Clock update, priority kill > frz > shift:
  - kill: all vld<=0, inflight<=0.
  - frz: all entries hold; inflight holds.
  - shift: entry k<=entry k-1 for k>=1. Entry 0<=new instruction if iss_vld && !stall && iss_we && iss_rd!=0, otherwise a bubble. Entry NSTAGE-1's previous content retires.
- inflight = number of vld entries after the update (registered next-state count).

## Timing
- Reset (asynchronous, resetn=0): all vld=0, rd=0, load=0, inflight=0. Consequently stall=0, busy=0, fwd_sel=0.
- Release of resetn is synchronous to clk; the first update happens at the first rising edge with resetn=1.
- stall, fwd_sel and busy are combinational from state and inputs in the same cycle, with no added latency.
- An issued instruction is visible as entry 0 one cycle after its issue edge and retires after NSTAGE unfrozen edges.
- Load-use with defaults: the dependent instruction stalls exactly 1 cycle, then forwards from entry 1 (fwd_sel=2).
- Issue while stall=1 is dropped (bubble inserted). Decode re-presents the same instruction next cycle.
- frz and kill asserted together: kill wins.
- kill mid-stall: stall drops the following cycle unless the new state matches.
- Reset mid-operation clears in-flight entries immediately, regardless of frz.

## Test plan
- ALU back-to-back (defaults): issue rd=5 ALU; next cycle src_reg[0]=5 -> stall=0, fwd_sel[0]=1. Then 2 and 3 on successive cycles as it ages; 0 after retirement.
- Load-use: issue rd=8 load; next cycle port1 reads 8 -> stall=1 for 1 cycle, then stall=0, fwd_sel[1]=2. inflight reads 1, 1 (bubble does not count), then follows retirement.
- Youngest priority: ALU rd=3 at entry 2, load rd=3 at entry 0, port0 reads 3 -> stall=1, fwd_sel[0]=0. No fall-through to entry 2.
- Register zero: issue iss_rd=0 iss_we=1, then read r0 -> entry stays invalid, stall=0, fwd_sel=0, inflight=0.
- Freeze/kill: 2 entries valid, frz=1 for 3 cycles -> fwd_sel unchanged, inflight=2. Assert kill with frz=1 -> next cycle busy=0, inflight=0.
- Parameter sweep NSTAGE=5, NRD=3, LOAD_RDY=2: load rd=9, reader on port2 -> stall for 2 cycles, then fwd_sel[2]=3. Assert resetn=0 mid-stall -> stall=0 immediately.
